// File: rtl/multibyte_serial_adder.sv
// rtl/multibyte_serial_adder.sv - byte-serial multi-precision adder driving an 8-bit ripple-carry adder
//
// ripple_carry_adder_8bit: combinational 8-bit adder.
//   a, b : 8-bit addends    cin  : carry in
//   s    : 8-bit sum        cout : carry out
//
// multibyte_serial_adder: adds two NBYTES-byte operands, one byte per clock,
// LSB byte first, chaining each byte's carry into the next.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only while idle
//   a, b  : W-bit operands (W = 8*NBYTES), captured on accepted start
//   cin   : carry into byte 0, captured on accepted start
//   busy  : high while an addition is in progress (exactly NBYTES cycles)
//   done  : one-cycle pulse when sum/cout hold a new result
//   sum   : result, held until the next completion
//   cout  : carry out of the top byte, held with sum

module ripple_carry_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module multibyte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_r_q, a_r_d;
  logic [W-1:0]    b_r_q, b_r_d;
  logic            c_r_q, c_r_d;
  logic [W-1:0]    wk_q, wk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [7:0]      rca_a, rca_b, rca_s;
  logic            rca_cout;

  assign rca_a = a_r_q[8*idx_q +: 8];
  assign rca_b = b_r_q[8*idx_q +: 8];

  ripple_carry_adder_8bit u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (c_r_q),
    .s    (rca_s),
    .cout (rca_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    c_r_d   = c_r_q;
    wk_d    = wk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_r_d   = a;
          b_r_d   = b;
          c_r_d   = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        wk_d[8*idx_q +: 8] = rca_s;
        c_r_d              = rca_cout;
        idx_d              = idx_q + CW'(1);
        if (idx_q == CW'(NBYTES - 1)) begin
          // wk_d already carries this edge's top byte, so it is the full result.
          sum_d   = wk_d;
          cout_d  = rca_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_r_q   <= '0;
      b_r_q   <= '0;
      c_r_q   <= 1'b0;
      wk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      c_r_q   <= c_r_d;
      wk_q    <= wk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_multibyte_serial_adder.sv
// tb/tb_multibyte_serial_adder.sv - directed and random checks of multibyte_serial_adder (NBYTES=4 and 1)

module tb_multibyte_serial_adder;

  logic        clk;
  logic        rst;

  logic        start;
  logic [31:0] a, b;
  logic        cin;
  logic        busy, done, cout;
  logic [31:0] sum;

  logic        start1;
  logic [7:0]  a1, b1;
  logic        cin1;
  logic        busy1, done1, cout1;
  logic [7:0]  sum1;

  int total;
  int bad;

  multibyte_serial_adder #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  multibyte_serial_adder #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin over 33 bits.
  function automatic logic [32:0] ref4(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  function automatic logic [8:0] ref1(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Launches one NBYTES=4 run from the current cycle, checks busy/done/held sum
  // on every run cycle, and returns in the done cycle.
  task automatic run4(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [31:0] prev;
    logic [32:0] exp;
    prev  = sum;
    exp   = ref4(x, y, c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    cin   = ~c;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      check({tag, "_held"}, 64'(sum), 64'(prev));
      tick();
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'({cout, sum}), 64'(exp));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [7:0]  r1a, r1b;
    logic        r1c;
    logic [32:0] e4;
    logic [8:0]  e1;
    int          ndone;

    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'({cout, sum}), 64'd0);
    check("rst1_out", 64'({busy1, done1, cout1, sum1}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Carry out of byte 0 into byte 1.
    run4("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    tick();
    check("t1_pulse_end", 64'(done), 64'd0);

    // Carry ripples through all bytes into cout.
    run4("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run4("t3", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    tick();

    // start while busy is ignored.
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) ndone++;
      if (k == 1) check("t4_result", 64'({cout, sum}), 64'h0_ACF1_3568);
      tick();
    end
    check("t4_one_done", 64'(ndone), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_hold", 64'({cout, sum}), 64'h0_ACF1_3568);

    // Reset after two RUN edges aborts the run.
    a     = 32'h0000_00FF;
    b     = 32'h0000_0001;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_sum", 64'({cout, sum}), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t5_no_done", 64'(done), 64'd0);
      check("t5_no_busy", 64'(busy), 64'd0);
      tick();
    end
    run4("t5_rerun", 32'h0000_00FF, 32'h0000_0001, 1'b0);

    // Back-to-back: second start issued in the done cycle.
    run4("t6_first", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
    run4("t6_second", 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Random runs for both widths; new operand pair launched in each done cycle.
    for (int i = 0; i < 10000; i++) begin
      ra     = $urandom;
      rb     = $urandom;
      rc     = 1'($urandom_range(0, 1));
      r1a    = 8'($urandom_range(0, 255));
      r1b    = 8'($urandom_range(0, 255));
      r1c    = 1'($urandom_range(0, 1));
      e4     = ref4(ra, rb, rc);
      e1     = ref1(r1a, r1b, r1c);
      a      = ra;
      b      = rb;
      cin    = rc;
      start  = 1'b1;
      a1     = r1a;
      b1     = r1b;
      cin1   = r1c;
      start1 = 1'b1;
      tick();
      start  = 1'b0;
      start1 = 1'b0;
      a      = $urandom;
      b      = $urandom;
      a1     = 8'($urandom_range(0, 255));
      tick();
      check("rnd1_done", 64'(done1), 64'd1);
      check("rnd1_result", 64'({cout1, sum1}), 64'(e1));
      tick();
      tick();
      tick();
      check("rnd4_done", 64'(done), 64'd1);
      check("rnd4_result", 64'({cout, sum}), 64'(e4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
